// File: rtl/stack_pkg.sv
// Shared defaults for the operand stack: word width, depth and pointer width.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;
    localparam int PTR_W       = $clog2(STACK_DEPTH) + 1;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack: stack pointer, registered read data, sticky error flags and command decode.
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     tos,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     errClr,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] ONE      = PW'(1);

    logic [PW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             is_empty, is_full;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             ovf_set, udf_set;

    assign is_empty  = (sp_q == '0);
    assign is_full   = (sp_q == FULL_CNT);
    // At sp == DEPTH the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
    assign mem_raddr = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        sp_d      = sp_q;
        dout_d    = dout_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q[AW-1:0];
        ovf_set   = 1'b0;
        udf_set   = 1'b0;

        if (pop) begin
            if (is_empty) begin
                udf_set = 1'b1;
                if (push) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + ONE;
                end
            end else begin
                dout_d = mem_rdata;
                if (push) begin
                    // Replace the top in place; depth is unchanged, so a full stack is fine.
                    mem_we    = 1'b1;
                    mem_waddr = mem_raddr;
                end else begin
                    sp_d = sp_q - ONE;
                end
            end
        end else begin
            if (tos) begin
                if (is_empty) begin
                    udf_set = 1'b1;
                end else begin
                    dout_d = mem_rdata;
                end
            end
            if (push) begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + ONE;
                end
            end
        end

        ovf_d = ovf_set | (ovf_q & ~errClr);
        udf_d = udf_set | (udf_q & ~errClr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (dataIn),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign dataOut   = dout_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = sp_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
